// File: rtl/status_sgpio_pkg.sv
// status_sgpio_pkg: shared state type, frame field positions and SLOAD pattern helper
// for the SGPIO initiator.
`default_nettype none

package status_sgpio_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sgpio_state_e;

  localparam int BITS_PER_DRIVE = 3;
  localparam int BIT_ACT        = 0;
  localparam int BIT_LOC        = 1;
  localparam int BIT_FAIL       = 2;
  localparam int SLOAD_VEND_LO  = 1;
  localparam int SLOAD_VEND_HI  = 4;

  // SLOAD value for frame bit k: frame marker, then L0..L3, then zeros.
  function automatic logic sload_bit(input int unsigned k, input logic [3:0] vendor);
    logic b;
    b = 1'b0;
    case (k)
      0:       b = 1'b1;
      1:       b = vendor[0];
      2:       b = vendor[1];
      3:       b = vendor[2];
      4:       b = vendor[3];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sgpio_clk_gen.sv
// sgpio_clk_gen: prescaler producing SCLK plus one-cycle rise/fall strobes;
// held at zero while run_i is low.
`default_nettype none

module sgpio_clk_gen #(
  parameter int CLK_DIV = 50
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  output logic sclk_o,
  output logic rise_stb_o,
  output logic fall_stb_o
);

  localparam int              CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] TC    = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             tc;

  assign tc = (cnt_q == TC);

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!run_i) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (tc) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o     = sclk_q;
  assign rise_stb_o = run_i & tc & ~sclk_q;
  assign fall_stb_o = run_i & tc & sclk_q;

endmodule

`default_nettype wire

// File: rtl/sgpio_initiator.sv
// sgpio_initiator: SFF-8485 SGPIO initiator serialising per-drive ACT/LOC/FAIL bits.
// Define SGPIO_INPUT_EN to add SDATAIN capture into DIN_STATUS.
`default_nettype none

module sgpio_initiator
  import status_sgpio_pkg::*;
#(
  parameter int NUM_DRIVES = 36,
  parameter int CLK_DIV    = 50
) (
  input  logic                                  SYSCLK,
  input  logic                                  RESET_N,
  input  logic                                  ENABLE,
  input  logic [NUM_DRIVES-1:0]                 ACT,
  input  logic [NUM_DRIVES-1:0]                 LOC,
  input  logic [NUM_DRIVES-1:0]                 FAIL,
  input  logic [3:0]                            VENDOR,
  output logic                                  SCLK,
  output logic                                  SLOAD,
  output logic                                  SDATAOUT,
  input  logic                                  SDATAIN,
  output logic [BITS_PER_DRIVE*NUM_DRIVES-1:0]  DIN_STATUS,
  output logic                                  FRAME_DONE,
  output logic                                  BUSY
);

  localparam int               FRAME_BITS = BITS_PER_DRIVE * NUM_DRIVES;
  localparam int               IDX_W      = $clog2(FRAME_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(FRAME_BITS - 1);

  sgpio_state_e           state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [FRAME_BITS-1:0]  shadow_q, shadow_d;
  logic [3:0]             vend_q, vend_d;
  logic                   sload_q, sload_d;
  logic                   sdo_q, sdo_d;
  logic                   done_q, done_d;

  logic [FRAME_BITS-1:0]  frame_in;
  logic [IDX_W-1:0]       idx_nxt;
  logic                   rise_stb, fall_stb, sclk;
  logic                   last_bit, start;

  sgpio_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk_i      (SYSCLK),
    .rst_ni     (RESET_N),
    .run_i      (state_q == RUN),
    .sclk_o     (sclk),
    .rise_stb_o (rise_stb),
    .fall_stb_o (fall_stb)
  );

  always_comb begin
    frame_in = '0;
    for (int d = 0; d < NUM_DRIVES; d++) begin
      frame_in[BITS_PER_DRIVE*d + BIT_ACT]  = ACT[d];
      frame_in[BITS_PER_DRIVE*d + BIT_LOC]  = LOC[d];
      frame_in[BITS_PER_DRIVE*d + BIT_FAIL] = FAIL[d];
    end
  end

  assign idx_nxt  = idx_q + IDX_W'(1);
  assign last_bit = (idx_q == LAST_IDX);
  // A new frame starts from idle or back-to-back on the closing fall of the last bit.
  assign start    = ENABLE & ((state_q == IDLE) | (fall_stb & last_bit));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    vend_d   = vend_q;
    sload_d  = sload_q;
    sdo_d    = sdo_q;
    done_d   = 1'b0;

    if (state_q == RUN && rise_stb && last_bit) begin
      done_d = 1'b1;
    end

    if (start) begin
      state_d  = RUN;
      shadow_d = frame_in;
      vend_d   = VENDOR;
      idx_d    = '0;
      sload_d  = 1'b1;
      sdo_d    = frame_in[0];
    end else if (state_q == RUN && fall_stb) begin
      if (!last_bit) begin
        idx_d   = idx_nxt;
        sload_d = sload_bit(32'(idx_nxt), vend_q);
        sdo_d   = shadow_q[idx_nxt];
      end else begin
        state_d = IDLE;
        idx_d   = '0;
        sload_d = 1'b0;
        sdo_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      vend_q   <= '0;
      sload_q  <= 1'b0;
      sdo_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      vend_q   <= vend_d;
      sload_q  <= sload_d;
      sdo_q    <= sdo_d;
      done_q   <= done_d;
    end
  end

`ifdef SGPIO_INPUT_EN
  logic                  sync1_q, sync2_q;
  logic [FRAME_BITS-1:0] cap_q, cap_d;
  logic [FRAME_BITS-1:0] din_q, din_d;

  // The final bit is folded in on the same rise that publishes the frame.
  always_comb begin
    cap_d = cap_q;
    din_d = din_q;
    if (rise_stb) begin
      cap_d[idx_q] = sync2_q;
      if (last_bit) begin
        din_d = cap_d;
      end
    end
  end

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cap_q   <= '0;
      din_q   <= '0;
    end else begin
      sync1_q <= SDATAIN;
      sync2_q <= sync1_q;
      cap_q   <= cap_d;
      din_q   <= din_d;
    end
  end

  assign DIN_STATUS = din_q;
`else
  logic unused_sdatain;
  assign unused_sdatain = SDATAIN;
  assign DIN_STATUS     = '0;
`endif

  assign SCLK       = sclk;
  assign SLOAD      = sload_q;
  assign SDATAOUT   = sdo_q;
  assign FRAME_DONE = done_q;
  assign BUSY       = (state_q == RUN);

endmodule

`default_nettype wire

// File: tb/tb_sgpio_initiator.sv
// tb_sgpio_initiator: frame-level reference model compared every cycle, directed
// frames with literal expectations, then randomized traffic.
`default_nettype none

module tb_sgpio_initiator;

  localparam int ND = 2;
  localparam int CD = 2;
  localparam int FB = 3 * ND;
  localparam int P  = 2 * CD;

  logic          SYSCLK  = 1'b0;
  logic          RESET_N = 1'b0;
  logic          ENABLE  = 1'b0;
  logic [ND-1:0] ACT     = '0;
  logic [ND-1:0] LOC     = '0;
  logic [ND-1:0] FAIL    = '0;
  logic [3:0]    VENDOR  = '0;
  logic          SDATAIN = 1'b0;
  logic          SCLK, SLOAD, SDATAOUT, FRAME_DONE, BUSY;
  logic [FB-1:0] DIN_STATUS;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  sgpio_initiator #(
    .NUM_DRIVES (ND),
    .CLK_DIV    (CD)
  ) dut (
    .SYSCLK     (SYSCLK),
    .RESET_N    (RESET_N),
    .ENABLE     (ENABLE),
    .ACT        (ACT),
    .LOC        (LOC),
    .FAIL       (FAIL),
    .VENDOR     (VENDOR),
    .SCLK       (SCLK),
    .SLOAD      (SLOAD),
    .SDATAOUT   (SDATAOUT),
    .SDATAIN    (SDATAIN),
    .DIN_STATUS (DIN_STATUS),
    .FRAME_DONE (FRAME_DONE),
    .BUSY       (BUSY)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model: time since frame start drives everything
  bit            m_busy = 1'b0;
  int            m_t    = 0;
  int            m_k    = 0;
  logic [FB-1:0] m_snap = '0;
  logic [FB-1:0] m_cap  = '0;
  logic [FB-1:0] m_din  = '0;
  logic [3:0]    m_vend = '0;
  bit            m_done = 1'b0;
  logic          h1 = 1'b0, h2 = 1'b0, m_s = 1'b0;

  function automatic logic [FB-1:0] frame_of(input logic [ND-1:0] a, input logic [ND-1:0] l,
                                             input logic [ND-1:0] f);
    logic [FB-1:0] r;
    r = '0;
    for (int d = 0; d < ND; d++) begin
      r[3*d]     = a[d];
      r[3*d + 1] = l[d];
      r[3*d + 2] = f[d];
    end
    return r;
  endfunction

  always @(posedge SYSCLK) begin
    cyc++;
    if (!RESET_N) begin
      m_busy = 1'b0; m_t = 0; m_snap = '0; m_cap = '0; m_din = '0;
      m_vend = '0; m_done = 1'b0; h1 = 1'b0; h2 = 1'b0;
    end else begin
      m_s = h2; h2 = h1; h1 = SDATAIN;
      m_done = 1'b0;
      if (!m_busy) begin
        if (ENABLE) begin
          m_snap = frame_of(ACT, LOC, FAIL); m_vend = VENDOR; m_busy = 1'b1; m_t = 0;
        end
      end else begin
        m_t++;
        if (m_t % P == CD) begin
          m_k = m_t / P;
          m_cap[m_k] = m_s;
          if (m_k == FB - 1) begin
            m_din  = m_cap;
            m_done = 1'b1;
          end
        end
        if (m_t == FB * P) begin
          if (ENABLE) begin
            m_snap = frame_of(ACT, LOC, FAIL); m_vend = VENDOR; m_t = 0;
          end else begin
            m_busy = 1'b0;
          end
        end
      end
    end
  end

  logic          e_sclk, e_sload, e_sdo;
  logic [FB-1:0] e_din, e_sh;
  logic [3:0]    e_vsh;
  int            e_k;

  always @(posedge SYSCLK) begin
    #1;
    e_sclk = 1'b0; e_sload = 1'b0; e_sdo = 1'b0;
    if (m_busy) begin
      e_k    = m_t / P;
      e_sclk = ((m_t % P) >= CD);
      e_sh   = m_snap >> e_k;
      e_sdo  = e_sh[0];
      if (e_k == 0) e_sload = 1'b1;
      else if (e_k <= 4) begin
        e_vsh   = m_vend >> (e_k - 1);
        e_sload = e_vsh[0];
      end
    end
`ifdef SGPIO_INPUT_EN
    e_din = m_din;
`else
    e_din = '0;
`endif
    check("model_sclk",       64'(SCLK),       64'(e_sclk));
    check("model_sload",      64'(SLOAD),      64'(e_sload));
    check("model_sdataout",   64'(SDATAOUT),   64'(e_sdo));
    check("model_busy",       64'(BUSY),       64'(m_busy));
    check("model_frame_done", 64'(FRAME_DONE), 64'(m_done));
    check("model_din_status", 64'(DIN_STATUS), 64'(e_din));
  end

  // ---------------- directed helpers
  task automatic wait_sclk(input logic lvl);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge SYSCLK); #2;
      if (SCLK === lvl) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("wait_sclk_timeout", 64'(SCLK), 64'(lvl));
  endtask

  localparam logic [FB-1:0] PAT = 6'b001011;
  int            rise0     = 0;
  int            last_done = 0;
  logic [FB-1:0] exp_din;

  task automatic run_frame(input int fn, input logic [FB-1:0] exp_sd, input logic [FB-1:0] exp_sl);
    for (int k = 0; k < FB; k++) begin
      wait_sclk(1'b1);
      check($sformatf("frame%0d_sdo_bit%0d", fn, k),   64'(SDATAOUT), 64'(exp_sd[k]));
      check($sformatf("frame%0d_sload_bit%0d", fn, k), 64'(SLOAD),    64'(exp_sl[k]));
      if (k == 0) rise0 = cyc;
      if (k == 1) check("sclk_period", 64'(cyc - rise0), 64'(4));
      SDATAIN = PAT[(k + 1) % FB];
      if (k == 2 && fn == 1) ACT = 2'b11;
      if (k == 2 && fn == 2) ENABLE = 1'b0;
      if (k == FB - 1) begin
        check($sformatf("frame%0d_done", fn), 64'(FRAME_DONE), 64'(1));
        check($sformatf("frame%0d_din", fn),  64'(DIN_STATUS), 64'(exp_din));
        if (fn == 2) check("frame_done_interval", 64'(cyc - last_done), 64'(24));
        last_done = cyc;
      end
      wait_sclk(1'b0);
    end
  endtask

  initial begin
`ifdef SGPIO_INPUT_EN
    exp_din = 6'b001011;
`else
    exp_din = '0;
`endif
    repeat (3) @(posedge SYSCLK);
    #2;
    check("reset_sclk",  64'(SCLK),       64'(0));
    check("reset_sload", 64'(SLOAD),      64'(0));
    check("reset_sdo",   64'(SDATAOUT),   64'(0));
    check("reset_busy",  64'(BUSY),       64'(0));
    check("reset_done",  64'(FRAME_DONE), 64'(0));
    check("reset_din",   64'(DIN_STATUS), 64'(0));

    @(negedge SYSCLK);
    RESET_N = 1'b1;
    @(negedge SYSCLK);
    ACT = 2'b01; LOC = 2'b10; FAIL = 2'b00; VENDOR = 4'b1010;
    SDATAIN = PAT[0];
    ENABLE = 1'b1;

    // Frame 1: ACT changes mid-frame; frame 2 picks it up and drops ENABLE mid-frame.
    run_frame(1, 6'b010001, 6'b010101);
    run_frame(2, 6'b011001, 6'b010101);

    repeat (8) @(posedge SYSCLK);
    #2;
    check("idle_busy",  64'(BUSY),     64'(0));
    check("idle_sclk",  64'(SCLK),     64'(0));
    check("idle_sload", 64'(SLOAD),    64'(0));
    check("idle_sdo",   64'(SDATAOUT), 64'(0));

    ENABLE = 1'b1;
    wait_sclk(1'b1);
    wait_sclk(1'b0);
    wait_sclk(1'b1);
    RESET_N = 1'b0;
    #1;
    check("async_rst_sclk",  64'(SCLK),       64'(0));
    check("async_rst_sload", 64'(SLOAD),      64'(0));
    check("async_rst_sdo",   64'(SDATAOUT),   64'(0));
    check("async_rst_busy",  64'(BUSY),       64'(0));
    check("async_rst_din",   64'(DIN_STATUS), 64'(0));
    @(negedge SYSCLK);
    @(negedge SYSCLK);
    RESET_N = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge SYSCLK); #2;
      if (BUSY === 1'b1) break;
    end
    check("restart_busy",  64'(BUSY),  64'(1));
    check("restart_sload", 64'(SLOAD), 64'(1));
    wait_sclk(1'b1);
    check("restart_rise_sload", 64'(SLOAD),    64'(1));
    check("restart_rise_sdo",   64'(SDATAOUT), 64'(1));

    for (int i = 0; i < 3000; i++) begin
      @(negedge SYSCLK);
      RESET_N = ($urandom_range(0, 799) != 0);
      SDATAIN = 1'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        ACT    = ND'($urandom);
        LOC    = ND'($urandom);
        FAIL   = ND'($urandom);
        VENDOR = 4'($urandom);
      end
      if ($urandom_range(0, 99) == 0) ENABLE = ~ENABLE;
    end
    @(negedge SYSCLK);
    RESET_N = 1'b1;
    repeat (2) @(posedge SYSCLK);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sgpio_initiator.md
Name: sgpio_initiator

Overview:
- SFF-8485 SGPIO initiator. Serialises per-drive activity/locate/fail bits onto SCLK/SLOAD/SDATAOUT for a downstream SGPIO target CPLD.
- Optionally captures returned SDATAIN bits.
- Sits beside the I2C register block. Lets the status CPLD drive a second backplane or a cascaded status board.

Parameters:
- NUM_DRIVES, 36, drives per bus; frame length FRAME_BITS = 3*NUM_DRIVES; must be >=2.
- CLK_DIV, 50, SYSCLK cycles per SCLK half-period; must be >=2.

Ports:
- SYSCLK  input  1  system clock.
- RESET_N  input  1  asynchronous active-low reset.
- ENABLE  input  1  level; 1 = run frames continuously.
- ACT  input  NUM_DRIVES  activity request per drive, 1 = on.
- LOC  input  NUM_DRIVES  locate request per drive.
- FAIL  input  NUM_DRIVES  fail request per drive.
- VENDOR  input  4  L0..L3 vendor bits carried on SLOAD.
- SCLK  output  1  SGPIO clock.
- SLOAD  output  1  frame marker plus vendor bits.
- SDATAOUT  output  1  serial drive data.
- SDATAIN  input  1  serial input from target, asynchronous.
- DIN_STATUS  output  FRAME_BITS  last complete captured input frame.
- FRAME_DONE  output  1  one-SYSCLK pulse per completed frame.
- BUSY  output  1  1 while a frame is in flight.

Behaviour:
- Reset: SCLK=0, SLOAD=0, SDATAOUT=0, DIN_STATUS=0, FRAME_DONE=0, BUSY=0, state IDLE, prescaler=0.
- States: IDLE, RUN.
- IDLE:
  - SCLK, SLOAD and SDATAOUT are held 0, and the prescaler is held 0.
  - When ENABLE=1 is sampled, the block snapshots ACT/LOC/FAIL/VENDOR into a shadow register.
  - Next cycle: bit index=0, SLOAD=1, SDATAOUT=ACT[0], BUSY=1, state RUN.
- RUN, clocking:
  - The prescaler counts 0..CLK_DIV-1. At terminal count it wraps to 0 and SCLK toggles.
  - 0->1 is the rise strobe; 1->0 is the fall strobe.
  - The first rise occurs CLK_DIV cycles after entering RUN.
- Bit order: bit k = 3*d + j, where d is the drive and j: 0=ACT[d], 1=LOC[d], 2=FAIL[d]. Bits are driven from the shadow register only.
- SLOAD pattern per frame: bit0=1; bits 1..4 = VENDOR[0..3]; bits 5..FRAME_BITS-1 = 0.
  - If FRAME_BITS<5, the vendor bits are truncated.
- Outputs SLOAD/SDATAOUT are registered and update on the fall strobe, so they are stable across each rise.
- Input path:
  - SDATAIN passes through a 2-flop synchroniser.
  - On each rise strobe, the synchronised value is shifted into capture bit k.
- On the rise of bit FRAME_BITS-1:
  - DIN_STATUS loads the capture register.
  - FRAME_DONE pulses for 1 cycle in the same cycle.
- On the following fall:
  - If ENABLE=1, a new snapshot is taken and bit0 is driven immediately, with no gap.
  - Otherwise the block returns to IDLE: SCLK stays 0, SLOAD/SDATAOUT=0, BUSY=0.
- ENABLE deasserted mid-frame: the current frame completes; it is never truncated.
- ACT/LOC/FAIL/VENDOR changes mid-frame are ignored until the next snapshot.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronous). DIN_STATUS is cleared, not updated.

Optional Feature:
- SGPIO_INPUT_EN defined:
  - SDATAIN synchroniser, capture shift register and DIN_STATUS update are present.
- SGPIO_INPUT_EN undefined:
  - SDATAIN is ignored and DIN_STATUS is tied to 0.
  - FRAME_DONE still pulses.
  - No capture flops are synthesised.

Decomposition:
- Shared package status_sgpio_pkg:
  - state enum (IDLE, RUN);
  - bit offsets BIT_ACT=0, BIT_LOC=1, BIT_FAIL=2;
  - SLOAD vendor field position (bits 1..4);
  - BITS_PER_DRIVE=3.
- One sub-module, sgpio_clk_gen: prescaler plus SCLK toggle. It outputs SCLK, rise_stb and fall_stb, with a run input that holds it at 0.

Test Plan:
- Basic frame. Setup: NUM_DRIVES=2, CLK_DIV=2, ACT=2'b01, LOC=2'b10, FAIL=0, VENDOR=4'b1010, ENABLE=1. Required response:
  - SDATAOUT sampled at rises = 1,0,0,0,1,0.
  - SLOAD at rises = 1,0,1,0,1,0.
  - SCLK period = 4 SYSCLK.
  - FRAME_DONE pulses once per 24 SYSCLK.
- Input capture: SDATAIN driven 1,1,0,1,0,0 at successive rises -> DIN_STATUS=6'b001011 in the FRAME_DONE cycle (with SGPIO_INPUT_EN).
- ENABLE dropped at bit 2 -> frame finishes all 6 bits, FRAME_DONE pulses, then BUSY=0 and SCLK/SLOAD/SDATAOUT stay 0.
- ACT changed 01->11 mid-frame -> current frame still sends 1,0,0,0,1,0; the next frame sends ACT[1]=1 at bit 3.
- RESET_N pulsed low mid-frame -> SCLK/SLOAD/SDATAOUT/BUSY=0 and DIN_STATUS=0 asynchronously. With ENABLE=1, restart begins with SLOAD=1 at bit0.
- SGPIO_INPUT_EN undefined, SDATAIN toggling -> DIN_STATUS stays 0 and FRAME_DONE still pulses every frame.
